// File: rtl/game_tick_gen_if.sv
// Bundle of game-timing control and status signals between the tick generator and its users.
// GAME_TICK_COUNT_EN adds the per-channel tick_cnt status bus.
interface game_tick_gen_if #(
  parameter int NUM_CH = 2,
  parameter int RATE_W = 2
);
  logic                     pause;
  logic                     step;
  logic [NUM_CH*RATE_W-1:0] rate;
  logic [NUM_CH*RATE_W-1:0] rate_act;
  logic [NUM_CH-1:0]        tick;
  logic [NUM_CH-1:0]        clk_game;
`ifdef GAME_TICK_COUNT_EN
  logic [NUM_CH*16-1:0]     tick_cnt;

  modport master (output pause, step, rate,
                  input  rate_act, tick, clk_game, tick_cnt);
  modport slave  (input  pause, step, rate,
                  output rate_act, tick, clk_game, tick_cnt);
`else
  modport master (output pause, step, rate,
                  input  rate_act, tick, clk_game);
  modport slave  (input  pause, step, rate,
                  output rate_act, tick, clk_game);
`endif
endinterface

// File: rtl/game_tick_gen.sv
// Multi-channel game tick generator: power-of-two rate table, pause, single-step, rate change at reload.
// Optional GAME_TICK_COUNT_EN adds a 16-bit wrapping tick counter per channel.
module game_tick_gen #(
  parameter int NUM_CH   = 2,
  parameter int RATE_W   = 2,
  parameter int BASE_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input logic              clk,
  input logic              rst,
  game_tick_gen_if.slave   bus
);

  logic [CNT_W-1:0]         cnt [NUM_CH];
  logic [NUM_CH*RATE_W-1:0] rate_q;
  logic [NUM_CH-1:0]        tick_q;
  logic [NUM_CH-1:0]        cg_q;
  logic [NUM_CH-1:0]        fire;

  function automatic logic [CNT_W-1:0] reload(input logic [RATE_W-1:0] r);
    return CNT_W'((BASE_DIV >> r) - 1);
  endfunction

  // A step only acts while paused; otherwise a channel fires when its count is spent.
  always_comb begin
    fire = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      fire[c] = bus.pause ? bus.step : (cnt[c] == '0);
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        rate_q[c*RATE_W +: RATE_W] <= bus.rate[c*RATE_W +: RATE_W];
        cnt[c]                     <= reload(bus.rate[c*RATE_W +: RATE_W]);
        tick_q[c]                  <= 1'b0;
        cg_q[c]                    <= 1'b0;
      end else if (fire[c]) begin
        rate_q[c*RATE_W +: RATE_W] <= bus.rate[c*RATE_W +: RATE_W];
        cnt[c]                     <= reload(bus.rate[c*RATE_W +: RATE_W]);
        tick_q[c]                  <= 1'b1;
        cg_q[c]                    <= ~cg_q[c];
      end else begin
        if (!bus.pause)
          cnt[c] <= cnt[c] - 1'b1;
        tick_q[c] <= 1'b0;
      end
    end
  end

  assign bus.tick     = tick_q;
  assign bus.clk_game = cg_q;
  assign bus.rate_act = rate_q;

`ifdef GAME_TICK_COUNT_EN
  logic [NUM_CH*16-1:0] tcnt_q;

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rst)
        tcnt_q[c*16 +: 16] <= '0;
      else if (fire[c])
        tcnt_q[c*16 +: 16] <= tcnt_q[c*16 +: 16] + 16'd1;
    end
  end

  assign bus.tick_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed plus randomized bench for game_tick_gen against an edges-remaining reference model.
module tb_game_tick_gen;
  localparam int NUM_CH   = 2;
  localparam int RATE_W   = 2;
  localparam int BASE_DIV = 16;
  localparam int CNT_W    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_tick_gen_if #(.NUM_CH(NUM_CH), .RATE_W(RATE_W)) bus();

  game_tick_gen #(
    .NUM_CH  (NUM_CH),
    .RATE_W  (RATE_W),
    .BASE_DIV(BASE_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: running edges still needed before the next tick, per channel.
  int left  [NUM_CH];
  int ract  [NUM_CH];
  int mtick [NUM_CH];
  int mcg   [NUM_CH];
  int mtcnt [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic p, input logic s,
                     input logic [NUM_CH*RATE_W-1:0] rt);
    logic [NUM_CH-1:0]        et, ec;
    logic [NUM_CH*RATE_W-1:0] er;
    logic [31:0]              etc;
    rst       = r;
    bus.pause = p;
    bus.step  = s;
    bus.rate  = rt;
    @(posedge clk);
    #1;
    etc = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int rsel, d, f;
      rsel = int'(rt[ch*RATE_W +: RATE_W]);
      d    = BASE_DIV / (1 << rsel);
      if (r) begin
        ract[ch] = rsel; left[ch] = d; mtick[ch] = 0; mcg[ch] = 0; mtcnt[ch] = 0;
      end else begin
        f = p ? int'(s) : int'(left[ch] == 1);
        if (f != 0) begin
          mtick[ch] = 1;
          mcg[ch]   = 1 - mcg[ch];
          ract[ch]  = rsel;
          left[ch]  = d;
          mtcnt[ch] = (mtcnt[ch] + 1) % 65536;
        end else begin
          mtick[ch] = 0;
          if (!p) left[ch] = left[ch] - 1;
        end
      end
      et[ch] = mtick[ch][0];
      ec[ch] = mcg[ch][0];
      er[ch*RATE_W +: RATE_W] = RATE_W'(ract[ch]);
      etc[ch*16 +: 16] = 16'(mtcnt[ch]);
    end
    chk("tick", 32'(bus.tick), 32'(et));
    chk("clk_game", 32'(bus.clk_game), 32'(ec));
    chk("rate_act", 32'(bus.rate_act), 32'(er));
`ifdef GAME_TICK_COUNT_EN
    chk("tick_cnt", bus.tick_cnt, etc);
`else
    if (etc === 32'hFFFF_FFFF) $display("unreachable");
`endif
  endtask

  initial begin : stim
    int t0 [$];
    int n1, n, gap;
    logic [3:0] rt;

    // Scenario 1: ch0 rate 0 (D=16), ch1 rate 3 (D=2)
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    chk("reset_tick", 32'(bus.tick), 32'd0);
    chk("reset_clk_game", 32'(bus.clk_game), 32'd0);
    chk("reset_rate_act", 32'(bus.rate_act), 32'hC);
    n1 = 0;
    for (int i = 1; i <= 48; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'b1100);
      if (bus.tick[0]) t0.push_back(i);
      if (bus.tick[1]) n1++;
    end
    chk("s1_ch0_ticks", 32'(t0.size()), 32'd3);
    if (t0.size() == 3) begin
      chk("s1_ch0_t1", 32'(t0[0]), 32'd16);
      chk("s1_ch0_t2", 32'(t0[1]), 32'd32);
      chk("s1_ch0_t3", 32'(t0[2]), 32'd48);
    end
    chk("s1_ch1_ticks", 32'(n1), 32'd24);

    // Scenario 2: rate change mid-period takes effect only after the next tick
    t0.delete();
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    for (int i = 1; i <= 24; i++) begin
      cyc(1'b0, 1'b0, 1'b0, (i < 5) ? 4'b1100 : 4'b1110);
      if (bus.tick[0]) t0.push_back(i);
      if (i == 15) chk("s2_ract_before", 32'(bus.rate_act[1:0]), 32'd0);
      if (i == 16) chk("s2_ract_after", 32'(bus.rate_act[1:0]), 32'd2);
    end
    chk("s2_ch0_ticks", 32'(t0.size()), 32'd3);
    if (t0.size() == 3) begin
      chk("s2_t1", 32'(t0[0]), 32'd16);
      chk("s2_t2", 32'(t0[1]), 32'd20);
      chk("s2_t3", 32'(t0[2]), 32'd24);
    end

    // Scenario 3: pause freezes everything; pending period resumes where it stopped
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    for (int i = 1; i <= 10; i++) cyc(1'b0, 1'b0, 1'b0, 4'b1100);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'b1100);
      chk("s3_pause_tick", 32'(bus.tick), 32'd0);
      chk("s3_pause_cg", 32'(bus.clk_game), 32'd2);
    end
    gap = 0;
    for (int i = 1; i <= 40 && gap == 0; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'b1100);
      if (bus.tick[0]) gap = i;
    end
    chk("s3_resume_gap", 32'(gap), 32'd6);

    // Scenario 4: single and back-to-back steps while paused; step ignored when running
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'b1100);
    n = 0; n1 = 0;
    cyc(1'b0, 1'b1, 1'b1, 4'b1100); n += int'(bus.tick[0]); n1 += int'(bus.tick[1]);
    cyc(1'b0, 1'b1, 1'b0, 4'b1100); n += int'(bus.tick[0]); n1 += int'(bus.tick[1]);
    cyc(1'b0, 1'b1, 1'b0, 4'b1100); n += int'(bus.tick[0]); n1 += int'(bus.tick[1]);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'b1100);
      chk("s4_b2b_tick", 32'(bus.tick), 32'd3);
      n += int'(bus.tick[0]); n1 += int'(bus.tick[1]);
    end
    chk("s4_ch0_steps", 32'(n), 32'd4);
    chk("s4_ch1_steps", 32'(n1), 32'd4);
    cyc(1'b0, 1'b0, 1'b1, 4'b1100);
    chk("s4_step_unpaused", 32'(bus.tick), 32'd0);

    // Scenario 5: reset mid-period with clk_game0 high
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    for (int i = 1; i <= 21; i++) cyc(1'b0, 1'b0, 1'b0, 4'b1100);
    chk("s5_cg0_high", 32'(bus.clk_game[0]), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    chk("s5_rst_tick", 32'(bus.tick), 32'd0);
    chk("s5_rst_cg", 32'(bus.clk_game), 32'd0);
    gap = 0;
    for (int i = 1; i <= 40 && gap == 0; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'b1100);
      if (bus.tick[0]) gap = i;
    end
    chk("s5_first_tick", 32'(gap), 32'd16);

    // Randomized traffic against the model
    rt = 4'($urandom);
    cyc(1'b1, 1'b0, 1'b0, rt);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) rt = 4'($urandom);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, rt);
    end

`ifdef GAME_TICK_COUNT_EN
    // Scenario 6: ch1 at D=2 for 131072 cycles wraps tick_cnt1 exactly once
    cyc(1'b1, 1'b0, 1'b0, 4'b1100);
    n = 0;
    for (int i = 1; i <= 131072; i++) begin
      logic [15:0] prev;
      prev = bus.tick_cnt[31:16];
      cyc(1'b0, 1'b0, 1'b0, 4'b1100);
      if (prev != 16'd0 && bus.tick_cnt[31:16] == 16'd0) n++;
    end
    chk("s6_wraps", 32'(n), 32'd1);
    chk("s6_tick_cnt1_end", 32'(bus.tick_cnt[31:16]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
